// File: rtl/snitch_tt_pkg.sv
// Shared types for the Snitch-to-memory arbiter slice.
// Latency: n/a (types, widths and a small helper only).
// Backpressure: n/a.
package snitch_tt_pkg;

  localparam int unsigned AddrWidth = 10;
  localparam int unsigned DataWidth = 32;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;

  // Origin of a read; also the round-robin pointer encoding.
  typedef enum logic {
    PortInst = 1'b0,
    PortData = 1'b1
  } port_id_e;

  function automatic port_id_e other_port(input port_id_e p);
    return (p == PortInst) ? PortData : PortInst;
  endfunction

endpackage

// File: rtl/snitch_mem_arbiter_if.sv
// Bundle of the fetch, data and memory request/response channels around the arbiter.
// Latency: n/a (wires only).
// Backpressure: valid/ready on every request and response channel.
interface snitch_mem_arbiter_if;
  import snitch_tt_pkg::*;

  addr_t inst_addr_i;
  logic  inst_valid_i;
  logic  inst_ready_o;
  data_t inst_data_o;
  logic  inst_rsp_valid_o;
  logic  inst_rsp_ready_i;

  addr_t data_addr_i;
  data_t data_wdata_i;
  logic  data_write_i;
  logic  data_wstrb_i;
  logic  data_valid_i;
  logic  data_ready_o;
  data_t data_rdata_o;
  logic  data_rsp_valid_o;
  logic  data_rsp_ready_i;

  addr_t mem_req_addr_o;
  data_t mem_req_data_o;
  logic  mem_req_write_o;
  logic  mem_req_wstrb_o;
  logic  mem_req_valid_o;
  logic  mem_req_ready_i;
  data_t mem_rsp_data_i;
  logic  mem_rsp_valid_i;
  logic  mem_rsp_ready_o;

  logic  err_o;

  // Arbiter side.
  modport slave (
    input  inst_addr_i, inst_valid_i, inst_rsp_ready_i,
    input  data_addr_i, data_wdata_i, data_write_i, data_wstrb_i, data_valid_i, data_rsp_ready_i,
    input  mem_req_ready_i, mem_rsp_data_i, mem_rsp_valid_i,
    output inst_ready_o, inst_data_o, inst_rsp_valid_o,
    output data_ready_o, data_rdata_o, data_rsp_valid_o,
    output mem_req_addr_o, mem_req_data_o, mem_req_write_o, mem_req_wstrb_o, mem_req_valid_o,
    output mem_rsp_ready_o, err_o
  );

  // Core plus memory side.
  modport master (
    output inst_addr_i, inst_valid_i, inst_rsp_ready_i,
    output data_addr_i, data_wdata_i, data_write_i, data_wstrb_i, data_valid_i, data_rsp_ready_i,
    output mem_req_ready_i, mem_rsp_data_i, mem_rsp_valid_i,
    input  inst_ready_o, inst_data_o, inst_rsp_valid_o,
    input  data_ready_o, data_rdata_o, data_rsp_valid_o,
    input  mem_req_addr_o, mem_req_data_o, mem_req_write_o, mem_req_wstrb_o, mem_req_valid_o,
    input  mem_rsp_ready_o, err_o
  );

endinterface

// File: rtl/snitch_mem_arbiter_id_fifo.sv
// Small FIFO of read-origin port ids, one entry per read in flight.
// Latency: push visible at head the cycle after; head is a direct register read.
// Backpressure: caller must not push when full nor pop when empty.
module snitch_id_fifo import snitch_tt_pkg::*; #(
  parameter int unsigned Depth = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  port_id_e push_id_i,
  input  logic     pop_i,
  output port_id_e head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  port_id_e            mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q;
  logic [PtrW-1:0]     rd_ptr_q;
  logic [CntW-1:0]     cnt_q;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= PortInst;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= wrap_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= wrap_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/snitch_mem_arbiter.sv
// Round-robin merge of Snitch fetch and data ports onto one memory port, reads routed back in order.
// Latency: zero-cycle combinational request and response paths; only rr pointer, origin FIFO, err are state.
// Backpressure: full origin FIFO blocks reads (writes pass); response stalls follow the head port's ready.
module snitch_mem_arbiter import snitch_tt_pkg::*; #(
  parameter int unsigned MaxOutstanding = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  snitch_mem_arbiter_if.slave bus
);

  port_id_e rr_q;
  port_id_e grant;
  port_id_e fifo_head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     fifo_push;
  logic     fifo_pop;
  logic     inst_elig;
  logic     data_elig;
  logic     req_vld;
  logic     req_hs;
  logic     rsp_rdy;
  logic     err_q;

  // A read needs a free origin slot; a full FIFO blocks reads even if a pop happens this cycle.
  assign inst_elig = bus.inst_valid_i && !fifo_full;
  assign data_elig = bus.data_valid_i && (bus.data_write_i || !fifo_full);
  assign req_vld   = inst_elig || data_elig;
  assign req_hs    = req_vld && bus.mem_req_ready_i;

  // Contention goes to the rr pointer port, otherwise to whichever port is eligible.
  always_comb begin
    grant = PortInst;
    if (inst_elig && data_elig) grant = rr_q;
    else if (data_elig)         grant = PortData;
  end

  assign bus.mem_req_valid_o = req_vld;
  assign bus.mem_req_addr_o  = (grant == PortData) ? bus.data_addr_i  : bus.inst_addr_i;
  assign bus.mem_req_data_o  = (grant == PortData) ? bus.data_wdata_i : '0;
  assign bus.mem_req_write_o = (grant == PortData) && bus.data_write_i;
  assign bus.mem_req_wstrb_o = (grant == PortData) && bus.data_wstrb_i;

  assign bus.inst_ready_o = req_vld && (grant == PortInst) && bus.mem_req_ready_i;
  assign bus.data_ready_o = req_vld && (grant == PortData) && bus.mem_req_ready_i;

  assign fifo_push = req_hs && ((grant == PortInst) || !bus.data_write_i);

  // With nothing outstanding a response is swallowed and flagged instead of stalling memory.
  assign rsp_rdy = fifo_empty ? 1'b1
                 : ((fifo_head == PortInst) ? bus.inst_rsp_ready_i : bus.data_rsp_ready_i);

  assign bus.mem_rsp_ready_o  = rsp_rdy;
  assign bus.inst_rsp_valid_o = bus.mem_rsp_valid_i && !fifo_empty && (fifo_head == PortInst);
  assign bus.data_rsp_valid_o = bus.mem_rsp_valid_i && !fifo_empty && (fifo_head == PortData);
  assign bus.inst_data_o      = bus.mem_rsp_data_i;
  assign bus.data_rdata_o     = bus.mem_rsp_data_i;
  assign bus.err_o            = err_q;

  assign fifo_pop = bus.mem_rsp_valid_i && rsp_rdy && !fifo_empty;

  snitch_id_fifo #(
    .Depth (MaxOutstanding)
  ) i_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (fifo_push),
    .push_id_i (grant),
    .pop_i     (fifo_pop),
    .head_o    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // After each accepted request the other port gets priority.
  always_ff @(posedge clk_i) begin
    if (rst_i)       rr_q <= PortInst;
    else if (req_hs) rr_q <= other_port(grant);
  end

  // Sticky flag for a response that had no read waiting for it.
  always_ff @(posedge clk_i) begin
    if (rst_i)                                   err_q <= 1'b0;
    else if (bus.mem_rsp_valid_i && fifo_empty)  err_q <= 1'b1;
  end

endmodule

// File: tb/tb_snitch_mem_arbiter.sv
module tb_snitch_mem_arbiter;
  import snitch_tt_pkg::*;

  localparam int MaxOut = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snitch_mem_arbiter_if bus();

  snitch_mem_arbiter #(.MaxOutstanding(MaxOut)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: origin of each outstanding read (0 = fetch, 1 = data), oldest first,
  // which port wins the next contention, and the sticky error.
  int org_q[$];
  int prefer = 0;
  bit err_m  = 1'b0;

  // Memory model and per-port scoreboards for the randomized run.
  logic [31:0] mem_m [1024];
  logic [31:0] rd_q[$];
  logic [31:0] inst_sb[$];
  logic [31:0] data_sb[$];

  function automatic int model_winner();
    bit room = (org_q.size() < MaxOut);
    bit ie   = bus.inst_valid_i && room;
    bit de   = bus.data_valid_i && (bus.data_write_i || room);
    if (ie && de) return prefer;
    if (ie) return 0;
    if (de) return 1;
    return -1;
  endfunction

  function automatic void model_update();
    int w;
    if (rst) begin
      org_q.delete();
      prefer = 0;
      err_m  = 1'b0;
      return;
    end
    w = model_winner();
    if (bus.mem_rsp_valid_i) begin
      if (org_q.size() == 0) err_m = 1'b1;
      else if ((org_q[0] == 0 && bus.inst_rsp_ready_i) || (org_q[0] == 1 && bus.data_rsp_ready_i))
        void'(org_q.pop_front());
    end
    if (w >= 0 && bus.mem_req_ready_i) begin
      prefer = 1 - w;
      if (w == 0 || !bus.data_write_i) org_q.push_back(w);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.inst_addr_i      = '0;
    bus.inst_valid_i     = 1'b0;
    bus.inst_rsp_ready_i = 1'b0;
    bus.data_addr_i      = '0;
    bus.data_wdata_i     = '0;
    bus.data_write_i     = 1'b0;
    bus.data_wstrb_i     = 1'b0;
    bus.data_valid_i     = 1'b0;
    bus.data_rsp_ready_i = 1'b0;
    bus.mem_req_ready_i  = 1'b0;
    bus.mem_rsp_data_i   = '0;
    bus.mem_rsp_valid_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.inst_ready_o, bus.data_ready_o, bus.mem_req_valid_o, bus.inst_rsp_valid_o,
         bus.data_rsp_valid_o, bus.err_o} !== 6'b000000) begin
      n_mis++;
      $display("FAIL reset_outputs: got %b want 000000", {bus.inst_ready_o, bus.data_ready_o,
               bus.mem_req_valid_o, bus.inst_rsp_valid_o, bus.data_rsp_valid_o, bus.err_o});
    end
    tick();
  endtask

  task automatic test_fetch();
    idle();
    bus.inst_valid_i    = 1'b1;
    bus.inst_addr_i     = 10'h004;
    bus.mem_req_ready_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.inst_ready_o, bus.data_ready_o} !== 2'b10) begin
      n_mis++;
      $display("FAIL fetch_ready: got %b want 10", {bus.inst_ready_o, bus.data_ready_o});
    end
    n_vec++;
    if ({bus.mem_req_valid_o, bus.mem_req_write_o, bus.mem_req_wstrb_o, bus.mem_req_addr_o,
         bus.mem_req_data_o} !== {3'b100, 10'h004, 32'h0}) begin
      n_mis++;
      $display("FAIL fetch_req: got v%b w%b s%b a%h d%h want v1 w0 s0 a004 d00000000",
               bus.mem_req_valid_o, bus.mem_req_write_o, bus.mem_req_wstrb_o,
               bus.mem_req_addr_o, bus.mem_req_data_o);
    end
    tick();
    bus.inst_valid_i     = 1'b0;
    bus.mem_rsp_valid_i  = 1'b1;
    bus.mem_rsp_data_i   = 32'h1050_0073;
    bus.inst_rsp_ready_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.inst_rsp_valid_o, bus.data_rsp_valid_o, bus.mem_rsp_ready_o} !== 3'b101
        || bus.inst_data_o !== 32'h1050_0073) begin
      n_mis++;
      $display("FAIL fetch_rsp: got iv%b dv%b mr%b data %h want iv1 dv0 mr1 data 10500073",
               bus.inst_rsp_valid_o, bus.data_rsp_valid_o, bus.mem_rsp_ready_o, bus.inst_data_o);
    end
    tick();
    idle();
    @(negedge clk);
    n_vec++;
    if (bus.err_o !== 1'b0) begin
      n_mis++;
      $display("FAIL fetch_no_err: got %b want 0", bus.err_o);
    end
    tick();
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_g;
    logic [1:0]  exp_r;
    logic [31:0] tag;
    do_reset();
    bus.inst_valid_i     = 1'b1;
    bus.inst_addr_i      = 10'h000;
    bus.data_valid_i     = 1'b1;
    bus.data_addr_i      = 10'h010;
    bus.mem_req_ready_i  = 1'b1;
    bus.inst_rsp_ready_i = 1'b1;
    bus.data_rsp_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin
        bus.inst_valid_i = 1'b0;
        bus.data_valid_i = 1'b0;
      end
      tag                 = 32'hA000_0000 + 32'(i - 1);
      bus.mem_rsp_valid_i = (i > 0);
      bus.mem_rsp_data_i  = tag;
      @(negedge clk);
      if (i < 6) begin
        exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
        n_vec++;
        if ({bus.inst_ready_o, bus.data_ready_o} !== exp_g) begin
          n_mis++;
          $display("FAIL alt_grant[%0d]: got %b want %b", i, {bus.inst_ready_o, bus.data_ready_o}, exp_g);
        end
      end
      if (i > 0) begin
        exp_r = ((i - 1) % 2 == 0) ? 2'b10 : 2'b01;
        n_vec++;
        if ({bus.inst_rsp_valid_o, bus.data_rsp_valid_o} !== exp_r
            || (exp_r[1] ? bus.inst_data_o : bus.data_rdata_o) !== tag) begin
          n_mis++;
          $display("FAIL alt_rsp[%0d]: got vld %b data %h/%h want vld %b data %h", i,
                   {bus.inst_rsp_valid_o, bus.data_rsp_valid_o}, bus.inst_data_o,
                   bus.data_rdata_o, exp_r, tag);
        end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    bus.data_valid_i    = 1'b1;
    bus.data_addr_i     = 10'h020;
    bus.mem_req_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.data_ready_o !== 1'b1) begin
        n_mis++;
        $display("FAIL full_load_accept[%0d]: got %b want 1", i, bus.data_ready_o);
      end
      tick();
    end
    bus.inst_valid_i = 1'b1;
    bus.inst_addr_i  = 10'h008;
    @(negedge clk);
    n_vec++;
    if ({bus.inst_ready_o, bus.data_ready_o, bus.mem_req_valid_o} !== 3'b000) begin
      n_mis++;
      $display("FAIL full_blocks_reads: got %b want 000",
               {bus.inst_ready_o, bus.data_ready_o, bus.mem_req_valid_o});
    end
    tick();
    bus.inst_valid_i = 1'b0;
    bus.data_write_i = 1'b1;
    bus.data_wstrb_i = 1'b1;
    bus.data_wdata_i = 32'h1234_5678;
    @(negedge clk);
    n_vec++;
    if ({bus.data_ready_o, bus.mem_req_valid_o, bus.mem_req_write_o, bus.mem_req_wstrb_o} !== 4'b1111
        || bus.mem_req_data_o !== 32'h1234_5678) begin
      n_mis++;
      $display("FAIL full_store_pass: got %b data %h want 1111 data 12345678",
               {bus.data_ready_o, bus.mem_req_valid_o, bus.mem_req_write_o, bus.mem_req_wstrb_o},
               bus.mem_req_data_o);
    end
    tick();
    bus.data_write_i     = 1'b0;
    bus.data_wstrb_i     = 1'b0;
    bus.mem_rsp_valid_i  = 1'b1;
    bus.mem_rsp_data_i   = 32'h0000_0001;
    bus.data_rsp_ready_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.data_ready_o, bus.data_rsp_valid_o, bus.mem_rsp_ready_o} !== 3'b011) begin
      n_mis++;
      $display("FAIL full_ignores_pop: got %b want 011",
               {bus.data_ready_o, bus.data_rsp_valid_o, bus.mem_rsp_ready_o});
    end
    tick();
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.data_ready_o !== 1'b1) begin
      n_mis++;
      $display("FAIL full_load_after_rsp: got %b want 1", bus.data_ready_o);
    end
    tick();
    bus.data_valid_i    = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.data_rsp_valid_o !== 1'b1) begin
        n_mis++;
        $display("FAIL full_drain[%0d]: got %b want 1", i, bus.data_rsp_valid_o);
      end
      tick();
    end
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.err_o !== 1'b0) begin
      n_mis++;
      $display("FAIL full_no_err: got %b want 0", bus.err_o);
    end
    tick();
    idle();
  endtask

  task automatic test_rsp_stall();
    do_reset();
    bus.data_valid_i    = 1'b1;
    bus.data_addr_i     = 10'h030;
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.data_valid_i     = 1'b0;
    bus.mem_rsp_valid_i  = 1'b1;
    bus.mem_rsp_data_i   = 32'hDEAD_BEEF;
    bus.data_rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.data_rsp_valid_o, bus.mem_rsp_ready_o} !== 2'b10) begin
        n_mis++;
        $display("FAIL stall_hold[%0d]: got %b want 10", i, {bus.data_rsp_valid_o, bus.mem_rsp_ready_o});
      end
      tick();
    end
    bus.data_rsp_ready_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.data_rsp_valid_o, bus.mem_rsp_ready_o} !== 2'b11 || bus.data_rdata_o !== 32'hDEAD_BEEF) begin
      n_mis++;
      $display("FAIL stall_release: got %b data %h want 11 data deadbeef",
               {bus.data_rsp_valid_o, bus.mem_rsp_ready_o}, bus.data_rdata_o);
    end
    tick();
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.data_rsp_valid_o, bus.err_o} !== 2'b00) begin
      n_mis++;
      $display("FAIL stall_after: got %b want 00", {bus.data_rsp_valid_o, bus.err_o});
    end
    tick();
    // A further beat must find nothing outstanding: the stalled read was popped exactly once.
    bus.mem_rsp_valid_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.inst_rsp_valid_o, bus.data_rsp_valid_o} !== 2'b00) begin
      n_mis++;
      $display("FAIL stall_single_pop: got %b want 00", {bus.inst_rsp_valid_o, bus.data_rsp_valid_o});
    end
    tick();
    idle();
  endtask

  task automatic test_unexpected();
    do_reset();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 32'h5555_AAAA;
    @(negedge clk);
    n_vec++;
    if ({bus.inst_rsp_valid_o, bus.data_rsp_valid_o, bus.mem_rsp_ready_o, bus.err_o} !== 4'b0010) begin
      n_mis++;
      $display("FAIL unexp_rsp: got %b want 0010",
               {bus.inst_rsp_valid_o, bus.data_rsp_valid_o, bus.mem_rsp_ready_o, bus.err_o});
    end
    tick();
    bus.mem_rsp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.err_o !== 1'b1) begin
        n_mis++;
        $display("FAIL unexp_sticky[%0d]: got %b want 1", i, bus.err_o);
      end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.data_valid_i    = 1'b1;
    bus.data_addr_i     = 10'h044;
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.data_valid_i = 1'b0;
    bus.inst_valid_i = 1'b1;
    bus.inst_addr_i  = 10'h040;
    tick();
    bus.inst_valid_i = 1'b0;
    bus.data_valid_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.data_ready_o, bus.mem_req_valid_o} !== 2'b00) begin
      n_mis++;
      $display("FAIL mid_full: got %b want 00", {bus.data_ready_o, bus.mem_req_valid_o});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.inst_valid_i    = 1'b1;
    bus.mem_req_ready_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.err_o, bus.mem_req_valid_o, bus.mem_req_write_o, bus.mem_req_addr_o} !== {3'b010, 10'h040}) begin
      n_mis++;
      $display("FAIL mid_reset_state: got err%b v%b w%b a%h want err0 v1 w0 a040",
               bus.err_o, bus.mem_req_valid_o, bus.mem_req_write_o, bus.mem_req_addr_o);
    end
    tick();
    idle();
    bus.mem_rsp_valid_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.inst_rsp_valid_o, bus.data_rsp_valid_o, bus.mem_rsp_ready_o} !== 3'b001) begin
      n_mis++;
      $display("FAIL mid_late_rsp: got %b want 001",
               {bus.inst_rsp_valid_o, bus.data_rsp_valid_o, bus.mem_rsp_ready_o});
    end
    tick();
    bus.mem_rsp_valid_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.err_o !== 1'b1) begin
      n_mis++;
      $display("FAIL mid_late_err: got %b want 1", bus.err_o);
    end
    tick();
  endtask

  task automatic test_random();
    int          w;
    int          head;
    logic [6:0]  exp_hs;
    logic [6:0]  got_hs;
    logic        exp_mr;
    logic [43:0] exp_req;
    logic [43:0] got_req;
    do_reset();
    rd_q.delete();
    inst_sb.delete();
    data_sb.delete();
    for (int i = 0; i < 1024; i++) mem_m[i] = $urandom;
    for (int c = 0; c < 3000; c++) begin
      bus.inst_valid_i     = ($urandom_range(0, 3) != 0);
      bus.inst_addr_i      = addr_t'($urandom);
      bus.data_valid_i     = ($urandom_range(0, 3) != 0);
      bus.data_addr_i      = addr_t'($urandom);
      bus.data_write_i     = ($urandom_range(0, 2) == 0);
      bus.data_wstrb_i     = ($urandom_range(0, 1) == 1);
      bus.data_wdata_i     = $urandom;
      bus.mem_req_ready_i  = ($urandom_range(0, 3) != 0);
      bus.inst_rsp_ready_i = ($urandom_range(0, 3) != 0);
      bus.data_rsp_ready_i = ($urandom_range(0, 3) != 0);
      bus.mem_rsp_valid_i  = (rd_q.size() > 0) && ($urandom_range(0, 2) != 0);
      bus.mem_rsp_data_i   = (rd_q.size() > 0) ? rd_q[0] : $urandom;
      @(negedge clk);
      w      = model_winner();
      head   = (org_q.size() > 0) ? org_q[0] : -1;
      exp_mr = (head < 0) ? 1'b1 : ((head == 0) ? bus.inst_rsp_ready_i : bus.data_rsp_ready_i);
      exp_hs = {(w == 0) && bus.mem_req_ready_i, (w == 1) && bus.mem_req_ready_i, (w >= 0),
                bus.mem_rsp_valid_i && (head == 0), bus.mem_rsp_valid_i && (head == 1),
                exp_mr, err_m};
      got_hs = {bus.inst_ready_o, bus.data_ready_o, bus.mem_req_valid_o, bus.inst_rsp_valid_o,
                bus.data_rsp_valid_o, bus.mem_rsp_ready_o, bus.err_o};
      n_vec++;
      if (got_hs !== exp_hs) begin
        n_mis++;
        $display("FAIL rand_hs[%0d]: got %b want %b (ir dr mv iv dv mr err)", c, got_hs, exp_hs);
      end
      if (w >= 0) begin
        exp_req = (w == 0) ? {bus.inst_addr_i, 2'b00, 32'h0}
                           : {bus.data_addr_i, bus.data_write_i, bus.data_wstrb_i, bus.data_wdata_i};
        got_req = {bus.mem_req_addr_o, bus.mem_req_write_o, bus.mem_req_wstrb_o, bus.mem_req_data_o};
        n_vec++;
        if (got_req !== exp_req) begin
          n_mis++;
          $display("FAIL rand_req[%0d]: got %h want %h (addr/write/strb/data)", c, got_req, exp_req);
        end
      end
      if (bus.mem_rsp_valid_i && head == 0 && bus.inst_rsp_ready_i) begin
        n_vec++;
        if (inst_sb.size() == 0 || bus.inst_data_o !== inst_sb[0]) begin
          n_mis++;
          $display("FAIL rand_inst_data[%0d]: got %h want %h", c, bus.inst_data_o,
                   (inst_sb.size() > 0) ? inst_sb[0] : 32'h0);
        end
      end
      if (bus.mem_rsp_valid_i && head == 1 && bus.data_rsp_ready_i) begin
        n_vec++;
        if (data_sb.size() == 0 || bus.data_rdata_o !== data_sb[0]) begin
          n_mis++;
          $display("FAIL rand_data_data[%0d]: got %h want %h", c, bus.data_rdata_o,
                   (data_sb.size() > 0) ? data_sb[0] : 32'h0);
        end
      end
      @(posedge clk);
      if (bus.mem_rsp_valid_i && head >= 0 && exp_mr) begin
        void'(rd_q.pop_front());
        if (head == 0 && inst_sb.size() > 0) void'(inst_sb.pop_front());
        if (head == 1 && data_sb.size() > 0) void'(data_sb.pop_front());
      end
      if (w >= 0 && bus.mem_req_ready_i) begin
        if (w == 1 && bus.data_write_i) begin
          if (bus.data_wstrb_i) mem_m[bus.data_addr_i] = bus.data_wdata_i;
        end else if (w == 0) begin
          rd_q.push_back(mem_m[bus.inst_addr_i]);
          inst_sb.push_back(mem_m[bus.inst_addr_i]);
        end else begin
          rd_q.push_back(mem_m[bus.data_addr_i]);
          data_sb.push_back(mem_m[bus.data_addr_i]);
        end
      end
      model_update();
      #1;
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_fetch();
    test_alternate();
    test_full();
    test_rsp_stall();
    test_unexpected();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
